// File: rtl/logic32_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pkg
//  Description : Shared op encodings, FSM state type and 1-bit op helper for
//                the bit-serial and parallel logic units.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_eval(input logic [1:0] op, input logic a, input logic b);
        logic y;
        y = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic32_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic32_serial_if
//  Description : Request/result bundle between a requester and the serial
//                logic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface logic32_serial_if #(
    parameter int LENGTH = 32
) ();
    logic              start;
    logic [1:0]        op;
    logic [LENGTH-1:0] X;
    logic [LENGTH-1:0] Y;
    logic              busy;
    logic              done;
    logic [LENGTH-1:0] Z;

    modport master (
        output start, op, X, Y,
        input  busy, done, Z
    );

    modport slave (
        input  start, op, X, Y,
        output busy, done, Z
    );
endinterface
`default_nettype wire

// File: rtl/logic32_serial_bit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_bit
//  Description : Combinational 1-bit evaluator for AND/OR/XOR/NOR.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_bit
    import logic_pkg::*;
(
    input  wire logic [1:0] op,
    input  wire logic       a,
    input  wire logic       b,
    output logic            y
);

    always_comb begin
        y = op_eval(op, a, b);
    end

endmodule
`default_nettype wire

// File: rtl/logic32_serial.sv
`default_nettype none
// ============================================================================
//  Module      : logic32_serial
//  Description : Bit-serial Z = X op Y, LSB first, one bit per clock, with a
//                start/busy/done handshake and a held result register.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic32_serial
    import logic_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    logic32_serial_if.slave bus
);

    localparam int            CW     = $clog2(LENGTH);
    localparam logic [CW-1:0] c_last = CW'(LENGTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [LENGTH-1:0] r_xs;
    logic [LENGTH-1:0] r_ys;
    logic [LENGTH-1:0] r_acc;
    logic [LENGTH-1:0] r_z;
    logic [1:0]        r_op;
    logic              r_busy;
    logic              r_done;
    logic              w_bit;
    logic              w_last;
    logic [LENGTH-1:0] w_acc_nxt;

    logic_bit u_bit (
        .op (r_op),
        .a  (r_xs[0]),
        .b  (r_ys[0]),
        .y  (w_bit)
    );

    assign w_last    = (r_cnt == c_last);
    assign w_acc_nxt = {w_bit, r_acc[LENGTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they come out of flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_xs   <= '0;
            r_ys   <= '0;
            r_acc  <= '0;
            r_z    <= '0;
            r_op   <= OP_AND;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_xs  <= bus.X;
                        r_ys  <= bus.Y;
                        r_op  <= bus.op;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_xs  <= r_xs >> 1;
                    r_ys  <= r_ys >> 1;
                    // Counter parks at the last index rather than wrapping.
                    if (w_last) begin
                        r_z <= w_acc_nxt;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_logic32_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic32_serial
//  Description : Directed self-checking bench for logic32_serial (LENGTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic32_serial;
    import logic_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   cyc;

    logic32_serial_if #(.LENGTH(32)) bus ();

    logic32_serial #(.LENGTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        logic [31:0] zold;
        int          n_cyc;
        int          n_busy;
        int          n_chg;
        bus.op    = o;
        bus.X     = x;
        bus.Y     = y;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        zold   = bus.Z;
        n_cyc  = 0;
        n_busy = 0;
        n_chg  = 0;
        while (!bus.done && n_cyc < 100) begin
            if (bus.busy) n_busy++;
            if (bus.Z !== zold) n_chg++;
            tick;
            n_cyc++;
        end
        if (bus.busy) n_busy++;
        check({tag, "_lat"}, 64'(n_cyc), 64'd32);
        check({tag, "_z"}, 64'(bus.Z), 64'(exp));
        check({tag, "_hold"}, 64'(n_chg), 64'd0);
        tick;
        check({tag, "_busy_n"}, 64'(n_busy), 64'd33);
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_idle_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int t0;
        int n_done;
        int last_done;
        int phase;
        int guard;

        n_total   = 0;
        n_bad     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_AND;
        bus.X     = '0;
        bus.Y     = '0;
        repeat (3) tick;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_z", 64'(bus.Z), 64'd0);
        rst_n = 1'b1;
        tick;

        run_op("or",  OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        run_op("and", OP_AND, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'h0E0D_B0E0);
        run_op("xor", OP_XOR, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'hD1A2_4E1F);
        run_op("nor", OP_NOR, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'h2050_0100);

        // start held high, operands disturbed mid-run and restored before recapture
        bus.op    = OP_OR;
        bus.X     = 32'h1;
        bus.Y     = 32'h2;
        bus.start = 1'b1;
        tick;
        t0        = cyc;
        n_done    = 0;
        last_done = 0;
        for (int i = 0; i < 110; i++) begin
            tick;
            phase = (cyc - t0) % 34;
            if (phase == 5) begin
                bus.op = OP_AND;
                bus.X  = 32'hFFFF_FFFF;
                bus.Y  = 32'h0;
            end else if (phase == 20) begin
                bus.op = OP_OR;
                bus.X  = 32'h1;
                bus.Y  = 32'h2;
            end
            if (bus.done) begin
                check("cont_z", 64'(bus.Z), 64'h3);
                if (n_done == 0) check("cont_first", 64'(cyc - t0), 64'd32);
                else             check("cont_gap", 64'(cyc - last_done), 64'd34);
                last_done = cyc;
                n_done++;
            end
        end
        check("cont_count", 64'(n_done), 64'd3);
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy && guard < 100) begin
            tick;
            guard++;
        end
        check("cont_drain", 64'(bus.busy), 64'd0);

        // reset aborts an operation in flight
        bus.op    = OP_XOR;
        bus.X     = 32'hDEAD_BEEF;
        bus.Y     = 32'h0F0F_F0F0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (10) tick;
        rst_n = 1'b0;
        tick;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_z", 64'(bus.Z), 64'd0);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (bus.done) n_done++;
        end
        check("abort_nodone", 64'(n_done), 64'd0);
        check("abort_zkeep", 64'(bus.Z), 64'd0);
        run_op("post", OP_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);

        // start pulses in RUN and in DONE are ignored
        bus.op    = OP_XOR;
        bus.X     = 32'hDEAD_BEEF;
        bus.Y     = 32'h0F0F_F0F0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n_done    = 0;
        guard     = 0;
        while (!bus.done && guard < 100) begin
            tick;
            guard++;
            if (guard == 5) begin
                bus.X     = 32'hFFFF_FFFF;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("oos_z", 64'(bus.Z), 64'hD1A2_4E1F);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("oos_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bus.done) n_done++;
        end
        check("oos_extra", 64'(n_done), 64'd0);
        check("oos_zkeep", 64'(bus.Z), 64'hD1A2_4E1F);

        // reset and start on the same edge
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.X     = 32'hFFFF_FFFF;
        bus.op    = OP_OR;
        tick;
        check("coll_busy", 64'(bus.busy), 64'd0);
        check("coll_z", 64'(bus.Z), 64'd0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        tick;
        check("coll_nocap", 64'(bus.busy), 64'd0);
        check("coll_z2", 64'(bus.Z), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic32_serial.md
# logic32_serial

Bit-serial bitwise logic unit computing Z = X op Y one bit per clock, LSB first, for op in {AND, OR, XOR, NOR}. It is the multi-cycle, handshaked counterpart to the team's single-cycle combinational gate blocks. It sits beside the ALU in the lab datapath, where area matters more than latency. Operands are captured on a start pulse, and the result is presented with a one-cycle done strobe.

## Interface
- LENGTH, 32: operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR; captured with start.
- X  input  LENGTH  operand A; captured with start.
- Y  input  LENGTH  operand B; captured with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; Z is valid and new.
- Z  output  LENGTH  result register; holds its value until the next completion.

## Operation
- Reset (rst_n low at a clk edge): state=IDLE, busy=0, done=0, Z=0, counter=0, shift registers=0.
- State machine:
  - IDLE: if start=1, capture X, Y, op into shift registers xs, ys, op_q; clear accumulator acc; counter=0; go to RUN. Otherwise stay.
  - RUN, each edge:
    - bit b = f(op_q, xs[0], ys[0]).
    - acc = {b, acc[LENGTH-1:1]}.
    - xs and ys shift right by one.
    - counter += 1.
    - When counter == LENGTH-1, that edge also loads Z = {b, acc[LENGTH-1:1]} and moves to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- start outside IDLE (RUN or DONE) is ignored, not queued. X, Y and op may change freely after capture.
- The counter is $clog2(LENGTH) bits wide and never wraps past LENGTH-1.
- Z changes only on the completion edge or on reset. It holds the previous result throughout RUN.
- Reset asserted mid-RUN or in DONE aborts the operation: Z=0, no done pulse, state IDLE.
- Simultaneous start and rst_n=0: reset wins.

## Timing
- start high at edge k gives RUN for edges k+1 .. k+LENGTH. Z is updated at edge k+LENGTH, and done is high during cycle k+LENGTH .. k+LENGTH+1.
- Latency from the capture edge to done asserted is LENGTH cycles; 32 for the default.
- Minimum issue interval is LENGTH+2 cycles: a start held high during DONE is accepted at the first IDLE edge.
- busy rises the cycle after capture and falls the cycle after done.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package logic_pkg holds:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - the state enum {S_IDLE, S_RUN, S_DONE}.
- Sub-module logic_bit: purely combinational 1-bit op evaluator (op, a, b -> y), reusable by the parallel gate blocks.
- Top level contains the FSM, counter, xs/ys/acc shift registers and the Z register.

## Test plan
All scenarios use LENGTH=32.
- OR: X=32'hF0F0_0000, Y=32'h0000_0F0F, start for one cycle → done exactly 32 cycles after the capture edge, Z=32'hF0F0_0F0F, busy high for 33 cycles.
- All ops on X=32'hDEAD_BEEF, Y=32'h0F0F_F0F0:
  - AND → 32'h0E0D_B0E0
  - XOR → 32'hD1A2_4E1F
  - NOR → 32'h2050_0100
  - Z holds the old value until each done.
- start held high continuously with X=32'h1, Y=32'h2, op=OR → captures occur 34 cycles apart, Z=32'h3 each time; mid-RUN changes to X/Y/op do not affect the result.
- Reset mid-op: assert rst_n=0 at cycle 10 of RUN → next edge busy=0, done=0, Z=0; no later done pulse; a subsequent operation completes normally.
- Out-of-state start: pulse start with X=32'hFFFF_FFFF during RUN and during DONE → ignored; the in-flight result is unchanged and no extra done pulse appears.
- Reset/start collision: rst_n=0 and start=1 on the same edge → IDLE with no capture; Z=0.
